// File: rtl/dual_port_rom_pkg.sv
// Shared constants and the contents formula for the dual-port lookup ROM.
// Imported by the read-port and top-level modules.
package dual_port_rom_pkg;

  localparam int unsigned DPR_ADDR_WIDTH = 10;
  localparam int unsigned DPR_DATA_WIDTH = 12;

  localparam int unsigned ROM_MULT   = 37;
  localparam int unsigned ROM_OFFSET = 1234;

  // Full 32-bit word; callers truncate to their data width.
  function automatic logic [31:0] rom_init(
    input int unsigned i
  );
    return i * ROM_MULT + ROM_OFFSET;
  endfunction

endpackage

// File: rtl/rom_read_port.sv
// One registered read port into the shared ROM array.
// Output clears asynchronously on reset; contents are untouched.
module rom_read_port
  import dual_port_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DPR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DPR_DATA_WIDTH,
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rom_i [DEPTH],
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] q_q;
  logic [DATA_WIDTH-1:0] q_d;

  assign q_d = rom_i[addr_i];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/dual_port_rom.sv
// Two-port synchronous ROM with formula-defined contents and
// one-cycle registered read latency on each port.
module dual_port_rom
  import dual_port_rom_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DPR_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DPR_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] q_a,
  output logic [DATA_WIDTH-1:0] q_b
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] rom [DEPTH];

  // Constant contents: both ports share this single array.
  for (genvar g = 0; g < DEPTH; g++) begin : g_init
    assign rom[g] = DATA_WIDTH'(rom_init(g));
  end

  rom_read_port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_a (
    .clk   (clk),
    .rst_n (rst_n),
    .rom_i (rom),
    .addr_i(addr_a),
    .q_o   (q_a)
  );

  rom_read_port #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_port_b (
    .clk   (clk),
    .rst_n (rst_n),
    .rom_i (rom),
    .addr_i(addr_b),
    .q_o   (q_b)
  );

endmodule

// File: tb/tb_dual_port_rom.sv
// Directed and random checks of the dual-port ROM against
// hand values and a small reference formula.
module tb_dual_port_rom;

  logic        clk;
  logic        rst_n;
  logic [9:0]  addr_a;
  logic [9:0]  addr_b;
  logic [11:0] q_a;
  logic [11:0] q_b;

  int n_chk;
  int n_err;

  dual_port_rom dut (
    .clk   (clk),
    .rst_n (rst_n),
    .addr_a(addr_a),
    .addr_b(addr_b),
    .q_a   (q_a),
    .q_b   (q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] rom_ref(input int i);
    int m;
    m = i % 1024;
    return 12'((m * 37 + 1234) % 4096);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [11:0] got,
    input logic [11:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ra;
    int rb;
    n_chk  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    addr_a = 10'd5;
    addr_b = 10'd9;

    // Reset holds outputs at zero through clock edges
    #1;
    chk("rst_a0", q_a, 12'd0);
    chk("rst_b0", q_b, 12'd0);
    repeat (3) begin
      step();
      chk("rst_a", q_a, 12'd0);
      chk("rst_b", q_b, 12'd0);
    end
    #2 rst_n = 1'b1;
    step();
    chk("rel_a", q_a, 12'd1419);
    chk("rel_b", q_b, 12'd1567);

    // Hand-computed spot values
    addr_a = 10'd0;    addr_b = 10'd1;
    step();
    chk("h0", q_a, 12'd1234);
    chk("h1", q_b, 12'd1271);
    addr_a = 10'd100;  addr_b = 10'd1023;
    step();
    chk("h100", q_a, 12'd838);
    chk("h1023", q_b, 12'd2221);

    // Sweep including 1024 wrapping to address 0
    for (int i = 0; i <= 1024; i++) begin
      addr_a = i[9:0];
      addr_b = i[9:0];
      step();
      chk("sweep_a", q_a, rom_ref(i));
      chk("sweep_b", q_b, rom_ref(i));
    end
    chk("wrap_a", q_a, 12'd1234);

    // Independent ports, then swapped
    addr_a = 10'd0;    addr_b = 10'd1023;
    step();
    chk("ind_a", q_a, 12'd1234);
    chk("ind_b", q_b, 12'd2221);
    addr_a = 10'd1023; addr_b = 10'd0;
    step();
    chk("swp_a", q_a, 12'd2221);
    chk("swp_b", q_b, 12'd1234);

    // Back-to-back addresses, no bubbles
    addr_a = 10'd1; addr_b = 10'd1;
    step();
    chk("b2b1", q_a, 12'd1271);
    addr_a = 10'd2; addr_b = 10'd3;
    step();
    chk("b2b2_a", q_a, 12'd1308);
    chk("b2b2_b", q_b, 12'd1345);
    addr_a = 10'd3; addr_b = 10'd2;
    step();
    chk("b2b3_a", q_a, 12'd1345);
    chk("b2b3_b", q_b, 12'd1308);

    // Hold address constant
    step();
    chk("hold_a", q_a, 12'd1345);

    // Random traffic with a mid-run asynchronous reset pulse
    for (int c = 0; c < 2000; c++) begin
      ra = int'($urandom_range(0, 1023));
      rb = (c % 7 == 0) ? ra : int'($urandom_range(0, 1023));
      addr_a = ra[9:0];
      addr_b = rb[9:0];
      step();
      chk("rnd_a", q_a, rom_ref(ra));
      chk("rnd_b", q_b, rom_ref(rb));
      if (c == 1000) begin
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_a", q_a, 12'd0);
        chk("mid_rst_b", q_b, 12'd0);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
